// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 constants and the prefix FSM state encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_ERR_LO = 8'h00;
    localparam logic [7:0] PS2_ERR_HI = 8'hFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } ps2_state_t;

endpackage

// File: rtl/ps2_key_slot.sv
// One tracked key: compares the broadcast event against its own code/ext
// and keeps the held level plus press/release pulses.
import ps2_pkg::*;

module ps2_key_slot #(
    parameter logic [7:0] CODE = 8'h00,
    parameter logic       EXT  = 1'b0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       clear_all,
    input  logic       make_v,
    input  logic       break_v,
    input  logic       ext,
    input  logic [7:0] code,
    output logic       held,
    output logic       press_pulse,
    output logic       release_pulse
);

    logic match;

    // Ext and non-ext keys with the same code are distinct keys.
    assign match = (code == CODE) && (ext == EXT);

    // Held level and one-cycle pulses; clear_all releases a held key at once.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            held          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (clear_all) begin
                held          <= 1'b0;
                release_pulse <= held;
            end else if (match) begin
                // A make on an already held key is typematic repeat: ignored.
                if (make_v && !held) begin
                    held        <= 1'b1;
                    press_pulse <= 1'b1;
                end
                // A break on a key that is not held is silently ignored.
                if (break_v && held) begin
                    held          <= 1'b0;
                    release_pulse <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 make/break decoder: E0/F0 prefix FSM with a prefix timeout,
// a one-cycle decoded-event broadcast, and one ps2_key_slot per tracked key.
// A byte sampled at edge N produces its event register at N and the key
// and error outputs at N+1.
import ps2_pkg::*;

module ps2_key_tracker #(
    parameter int                      NUM_KEYS       = 3,
    parameter logic [NUM_KEYS*8-1:0]   KEY_CODES      = {8'h2d, 8'h1d, 8'h1b},
    parameter logic [NUM_KEYS-1:0]     KEY_EXT        = '0,
    parameter int                      TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                code_valid,
    input  logic [7:0]          code_in,
    input  logic                clear_all,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                any_held,
    output logic                error
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t       state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    logic             is_err_byte;
    logic             nxt_make, nxt_break, nxt_ext, nxt_err;
    logic             ev_make, ev_break, ev_ext;
    logic [7:0]       ev_code;
    logic             err_q;

    assign is_err_byte = (code_in == PS2_ERR_LO) || (code_in == PS2_ERR_HI);
    assign timeout     = (state != IDLE) && (cnt == CNT_LAST);
    assign any_held    = |key_held;

    // Prefix FSM next state and decoded event; a new byte beats a timeout.
    always_comb begin
        next_state = state;
        nxt_make   = 1'b0;
        nxt_break  = 1'b0;
        nxt_ext    = 1'b0;
        nxt_err    = 1'b0;
        if (code_valid) begin
            case (state)
                IDLE: begin
                    if (code_in == PS2_EXT)        next_state = GOT_E0;
                    else if (code_in == PS2_BREAK) next_state = GOT_F0;
                    else if (is_err_byte)          nxt_err    = 1'b1;
                    else                           nxt_make   = 1'b1;
                end
                GOT_E0: begin
                    if (code_in == PS2_BREAK) begin
                        next_state = GOT_E0F0;
                    end else if (code_in == PS2_EXT) begin
                        nxt_err = 1'b1;
                    end else if (is_err_byte) begin
                        nxt_err    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        nxt_make   = 1'b1;
                        nxt_ext    = 1'b1;
                        next_state = IDLE;
                    end
                end
                GOT_F0, GOT_E0F0: begin
                    next_state = IDLE;
                    if (code_in == PS2_EXT || code_in == PS2_BREAK || is_err_byte) begin
                        nxt_err = 1'b1;
                    end else begin
                        nxt_break = 1'b1;
                        nxt_ext   = (state == GOT_E0F0);
                    end
                end
                default: next_state = IDLE;
            endcase
        end else if (timeout) begin
            next_state = IDLE;
            nxt_err    = 1'b1;
        end
    end

    // State, timeout counter, event broadcast register and error pipeline.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            ev_make  <= 1'b0;
            ev_break <= 1'b0;
            ev_ext   <= 1'b0;
            ev_code  <= 8'h00;
            err_q    <= 1'b0;
            error    <= 1'b0;
        end else if (clear_all) begin
            state    <= IDLE;
            cnt      <= '0;
            ev_make  <= 1'b0;
            ev_break <= 1'b0;
            ev_ext   <= 1'b0;
            err_q    <= 1'b0;
            error    <= err_q;
        end else begin
            state    <= next_state;
            // Counter only advances while waiting for a prefix follow-up.
            if (code_valid || next_state == IDLE) cnt <= '0;
            else                                  cnt <= cnt + 1'b1;
            ev_make  <= nxt_make;
            ev_break <= nxt_break;
            ev_ext   <= nxt_ext;
            ev_code  <= code_in;
            err_q    <= nxt_err;
            error    <= err_q;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_slot
        ps2_key_slot #(
            .CODE (KEY_CODES[8*i +: 8]),
            .EXT  (KEY_EXT[i])
        ) u_slot (
            .clock         (clock),
            .resetn        (resetn),
            .clear_all     (clear_all),
            .make_v        (ev_make),
            .break_v       (ev_break),
            .ext           (ev_ext),
            .code          (ev_code),
            .held          (key_held[i]),
            .press_pulse   (key_press[i]),
            .release_pulse (key_release[i])
        );
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised make/break decoder for PS/2 Set-2 scan codes, sitting between the keyboard/oneshot receiver and the game control unit. Consumes one scan byte per strobe and tracks an E0/F0 prefix state machine. Maintains a held bit per configured key, plus one-cycle press and release pulses. Replaces fixed two-byte history compares. Adds:
- extended (E0) key support
- typematic-repeat suppression
- prefix timeout
- error reporting

Parameters:
NUM_KEYS, 3, number of tracked keys (1..16)
KEY_CODES, {8'h2d,8'h1d,8'h1b}, packed NUM_KEYS*8 code table; slot i = bits [8i+7:8i] (default: slot0 S, slot1 W, slot2 R)
KEY_EXT, 3'b000, per-slot flag: 1 = key is E0-prefixed (arrow keys etc.)
TIMEOUT_CYCLES, 2_500_000, max cycles between prefix byte and its follow-up (50 ms at 50 MHz)

Ports:
clock  input  1  system clock (50 MHz)
resetn  input  1  synchronous active-low reset
code_valid  input  1  one-cycle strobe: code_in holds a new scan byte
code_in  input  8  scan byte, sampled only when code_valid=1
clear_all  input  1  synchronous flush of all held keys (game restart)
key_held  output  NUM_KEYS  level: key i currently down
key_press  output  NUM_KEYS  one-cycle pulse on key i going up->down
key_release  output  NUM_KEYS  one-cycle pulse on key i going down->up
any_held  output  1  OR of key_held
error  output  1  one-cycle pulse on protocol error or prefix timeout

Behaviour:
- Reset (resetn=0 at posedge clock):
  - state IDLE, timeout counter 0
  - key_held, key_press, key_release, error all 0
  - code_valid is ignored during reset
- All outputs are registered. An event caused by a byte sampled at edge N is visible after edge N+1; pulses last exactly one cycle.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions occur only on code_valid, except on timeout.
  - IDLE:
    - E0 -> GOT_E0
    - F0 -> GOT_F0
    - 00 or FF -> error pulse, stay IDLE
    - any other byte b -> make(b, ext=0)
  - GOT_E0:
    - F0 -> GOT_E0F0
    - E0 -> error, stay GOT_E0
    - 00/FF -> error, IDLE
    - else -> make(b, ext=1), IDLE
  - GOT_F0:
    - E0, F0, 00 or FF -> error, IDLE
    - else -> break(b, ext=0), IDLE
  - GOT_E0F0:
    - E0, F0, 00 or FF -> error, IDLE
    - else -> break(b, ext=1), IDLE
- make(b, x): for every slot i with KEY_CODES[i]==b and KEY_EXT[i]==x:
  - if key_held[i]=0: set key_held[i], pulse key_press[i]
  - if already held (typematic repeat): no change, no pulse
- break(b, x): for every matching slot:
  - if held: clear key_held[i], pulse key_release[i]
  - if not held: no effect, no error
- Unmatched codes: no output change and no error. Duplicate table entries: all matching slots update together.
- Timeout:
  - counter runs only in non-IDLE states and restarts on each code_valid
  - on reaching TIMEOUT_CYCLES-1: FSM -> IDLE, error pulse, key_held unchanged
- clear_all:
  - FSM -> IDLE, counter 0
  - every held key clears and gets a key_release pulse in the same cycle
  - if code_valid coincides, clear_all wins and the byte is dropped
- The ext/non-ext distinction is strict: E0 1D does not match a slot with KEY_EXT=0 and code 1D.
- The block never stalls; a code_valid arriving every cycle is legal.
- any_held is combinational from key_held (no extra latency).

Decomposition:
- Shared package ps2_pkg holds:
  - constants PS2_EXT=8'hE0, PS2_BREAK=8'hF0, PS2_ERR_LO=8'h00, PS2_ERR_HI=8'hFF
  - the 2-bit state encoding (IDLE=0, GOT_E0=1, GOT_F0=2, GOT_E0F0=3)
- Top level holds the prefix FSM and timeout counter. It broadcasts decoded events {make_v, break_v, ext, code} for one cycle.
- Sub-module ps2_key_slot (parameters CODE, EXT) is instantiated NUM_KEYS times by generate. Each instance holds its own held/press/release registers and handles clear_all.

Test Plan:
- Reset then byte 1D -> key_held=3'b010, key_press=3'b010 for one cycle after the sample edge; any_held=1.
- Bytes 1D,1D,1D (typematic) then F0,1D -> exactly one press pulse; one key_release=3'b010 pulse after the 1D following F0; key_held=0.
- Two instances side by side:
  - With KEY_EXT=3'b001: E0,1B -> slot0 press.
  - With KEY_EXT=3'b000: the plain 1B bytes of the same E0,1B stream press slot0; the E0-prefixed 1B is ignored.
  - E0,F0,1B on the ext instance -> slot0 release.
- F0 followed by silence for TIMEOUT_CYCLES (set to 16 in bench) -> error pulse at cycle 16, FSM IDLE. Next 2D -> slot2 press, not release.
- Protocol errors:
  - F0,F0 -> error pulse, no release.
  - Byte FF in IDLE -> error pulse, key_held unchanged.
- Hold 1B and 2D, assert clear_all with code_valid=1, code_in=1D -> key_release=3'b101, key_held=0, slot1 not pressed. Assert resetn=0 mid-prefix (after E0) -> all outputs 0 next cycle, FSM IDLE.
